// File: rtl/guess_pkg.sv
// Shared types and constants for the guessing-game input front end.
package guess_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  // Largest legal secret or guess value.
  localparam int unsigned MAX_DIGIT_DEF = 9;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Board push-keys pull low when pressed.
  localparam logic KEY_ACTIVE   = 1'b0;
  localparam logic KEY_RELEASED = ~KEY_ACTIVE;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counter debouncer for one active-low push-key.
// key_press pulses for one cycle when the debounced level goes to pressed.
module key_debounce
  import guess_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a level change only after it has been stable for LAST+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= KEY_RELEASED;
      sync2     <= KEY_RELEASED;
      level     <= KEY_RELEASED;
      cnt       <= '0;
      key_press <= 1'b0;
    end else begin
      sync1     <= key_raw;
      sync2     <= sync1;
      key_press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level     <= sync2;
          cnt       <= '0;
          key_press <= (sync2 == KEY_ACTIVE);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/guess_input_ctrl.sv
// Front end for the guessing-game core: debounced keys, synced guess switches,
// LFSR-drawn secret digit and single-cycle strobes toward the core.
module guess_input_ctrl
  import guess_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter int unsigned MAX_DIGIT       = MAX_DIGIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_guess,
  input  logic       key_submit,
  input  logic       key_new,
  output logic [3:0] guess_number,
  output logic [3:0] initial_number,
  output logic       guess_valid,
  output logic       guess_err,
  output logic       new_round,
  output logic       playing
);

  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] MAX_D    = 4'(MAX_DIGIT);

  state_t     state;
  logic [7:0] lfsr;
  logic [3:0] sw_s1;
  logic [3:0] sw_s2;
  logic       submit_ev;
  logic       new_ev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_submit (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_submit),
    .key_press (submit_ev)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_new),
    .key_press (new_ev)
  );

  // Guess switches are only synchronised; they are sampled at an accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_guess;
      sw_s2 <= sw_s1;
    end
  end

  // Free-running LFSR; a non-zero seed keeps it off the all-zero lock-up state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Round control with registered strobes; a new event outranks a submit event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      guess_number   <= '0;
      initial_number <= '0;
      guess_valid    <= 1'b0;
      guess_err      <= 1'b0;
      new_round      <= 1'b0;
      playing        <= 1'b0;
    end else begin
      guess_valid <= 1'b0;
      guess_err   <= 1'b0;
      new_round   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (new_ev) begin
            state <= S_GEN;
          end
        end
        S_GEN: begin
          // Reject-sample the low nibble until it is a legal digit.
          if (lfsr[3:0] <= MAX_D) begin
            initial_number <= lfsr[3:0];
            new_round      <= 1'b1;
            playing        <= 1'b1;
            state          <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (new_ev) begin
            state   <= S_GEN;
            playing <= 1'b0;
          end else if (submit_ev) begin
            if (sw_s2 <= MAX_D) begin
              guess_number <= sw_s2;
              guess_valid  <= 1'b1;
            end else begin
              guess_err <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_input_ctrl.sv
// Directed and randomised bench for guess_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_guess_input_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_guess = 4'd0;
  logic       key_submit = 1'b1;
  logic       key_new = 1'b1;
  logic [3:0] guess_number;
  logic [3:0] initial_number;
  logic       guess_valid;
  logic       guess_err;
  logic       new_round;
  logic       playing;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference state: what the core should currently be showing.
  logic [7:0] m_lfsr;
  logic       m_play = 1'b0;
  logic [3:0] m_guess = 4'd0;
  logic [3:0] m_secret = 4'd0;

  guess_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .LFSR_SEED       (8'hA5),
    .MAX_DIGIT       (9)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw_guess       (sw_guess),
    .key_submit     (key_submit),
    .key_new        (key_new),
    .guess_number   (guess_number),
    .initial_number (initial_number),
    .guess_valid    (guess_valid),
    .guess_err      (guess_err),
    .new_round      (new_round),
    .playing        (playing)
  );

  always #5 clk = ~clk;

  // Polynomial x^8+x^6+x^5+x^4+1: feedback from stages 8,6,5,4 shifted in at the bottom.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".guess_number"},   8'(guess_number),   8'h0);
    check({tag, ".initial_number"}, 8'(initial_number), 8'h0);
    check({tag, ".guess_valid"},    8'(guess_valid),    8'h0);
    check({tag, ".guess_err"},      8'(guess_err),      8'h0);
    check({tag, ".new_round"},      8'(new_round),      8'h0);
    check({tag, ".playing"},        8'(playing),        8'h0);
  endtask

  // Cycles with no accepted key action: nothing may change.
  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("quiet.new_round",      8'(new_round),      8'h0);
      check("quiet.guess_valid",    8'(guess_valid),    8'h0);
      check("quiet.guess_err",      8'(guess_err),      8'h0);
      check("quiet.guess_number",   8'(guess_number),   8'(m_guess));
      check("quiet.initial_number", 8'(initial_number), 8'(m_secret));
      check("quiet.playing",        8'(playing),        8'(m_play));
    end
  endtask

  // Press the chosen keys on the same cycle, hold them, release, and check every cycle.
  // Edge n=1 is the first clock that samples the raw press; an accepted press acts at n=7.
  // abort_n>0 drives reset right after edge abort_n.
  task automatic run_press(input bit sub, input bit nw, input logic [3:0] sw, input int abort_n);
    int         limit = 22;
    int         hit = 1000;
    logic [7:0] v = 8'h00;
    bit         old_play = m_play;
    bit         acc;
    @(negedge clk);
    sw_guess = sw;
    if (sub) key_submit = 1'b0;
    if (nw)  key_new = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if (n == abort_n) begin
        key_submit = 1'b1;
        key_new = 1'b1;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        m_play = 1'b0;
        m_guess = 4'd0;
        m_secret = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        quiet(15);
        return;
      end
      if (nw && n == 7) begin
        v = m_lfsr;
        hit = 0;
        while (v[3:0] > 4'd9 && hit < 300) begin
          v = lfsr_step(v);
          hit++;
        end
        if (8 + hit + 3 > limit) limit = 8 + hit + 3;
      end
      acc = sub && !nw && old_play && (n == 7);
      check("new_round",   8'(new_round),   8'(nw && (n == 8 + hit)));
      check("guess_valid", 8'(guess_valid), 8'(acc && (sw <= 4'd9)));
      check("guess_err",   8'(guess_err),   8'(acc && (sw > 4'd9)));
      if (acc && sw <= 4'd9) m_guess = sw;
      if (nw && n == 7) m_play = 1'b0;
      if (nw && n == 8 + hit) begin
        m_secret = v[3:0];
        m_play = 1'b1;
      end
      check("guess_number",   8'(guess_number),   8'(m_guess));
      check("initial_number", 8'(initial_number), 8'(m_secret));
      check("playing",        8'(playing),        8'(m_play));
    end
    @(negedge clk);
    key_submit = 1'b1;
    key_new = 1'b1;
    quiet(10);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    quiet(3);

    // Submit while idle is ignored.
    run_press(1'b1, 1'b0, 4'd3, 0);
    // First round.
    run_press(1'b0, 1'b1, 4'd0, 0);
    // Two-cycle glitch on submit must not register.
    @(negedge clk);
    sw_guess = 4'd7;
    key_submit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    key_submit = 1'b1;
    quiet(12);
    // Clean legal guess, then an out-of-range one.
    run_press(1'b1, 1'b0, 4'd7, 0);
    run_press(1'b1, 1'b0, 4'd12, 0);
    // Simultaneous new and submit: new wins.
    run_press(1'b1, 1'b1, 4'd9, 0);

    // Randomised play with random phase gaps.
    for (int i = 0; i < 10; i++) begin
      quiet(int'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) run_press(1'b0, 1'b1, 4'd0, 0);
      else                           run_press(1'b1, 1'b0, 4'($urandom_range(0, 15)), 0);
    end
    run_press(1'b1, 1'b0, 4'd9, 0);
    run_press(1'b1, 1'b0, 4'd10, 0);

    // Reset during round generation, then during a debounce.
    run_press(1'b0, 1'b1, 4'd0, 7);
    run_press(1'b1, 1'b0, 4'd5, 3);
    // A fresh press works after reset.
    run_press(1'b0, 1'b1, 4'd0, 0);
    run_press(1'b1, 1'b0, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
